// File: rtl/cdb_slot_scheduler_pkg.sv
// Shared definitions for the CDB write-back slot scheduler and its RS clients.
package cdb_slot_scheduler_pkg;

  localparam int CDB_SZ          = 2;
  localparam int NUM_ISSUE       = 3;
  localparam int CDB_SCHED_DEPTH = 8;
  localparam int ALU_LATENCY     = 1;
  localparam int MULT_LATENCY    = 4;

  localparam int CDB_CNT_W = $clog2(CDB_SZ + 1);
  localparam int CDB_LAT_W = $clog2(CDB_SCHED_DEPTH);

  typedef logic [CDB_CNT_W-1:0] CDB_RESV_CNT;
  typedef logic [CDB_LAT_W-1:0] CDB_SCHED_LAT;

  // A single-lane build still needs a one-bit start index.
  function automatic int prio_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_resv_grant.sv
// Combinational grant scan: walks lanes from start_i, granting while the
// running per-target count (ring plus grants given this cycle) is below capacity.
module cdb_resv_grant
  import cdb_slot_scheduler_pkg::*;
#(
  parameter int CDB_WIDTH  = CDB_SZ,
  parameter int NUM_REQ    = NUM_ISSUE,
  parameter int MAX_LAT    = CDB_SCHED_DEPTH,
  parameter int LAT_WIDTH  = $clog2(MAX_LAT),
  parameter int CNT_WIDTH  = $clog2(CDB_WIDTH + 1),
  parameter int PRIO_WIDTH = prio_width(NUM_REQ)
) (
  input  logic                           en_i,
  input  logic [MAX_LAT*CNT_WIDTH-1:0]   ring_i,
  input  logic [LAT_WIDTH-1:0]           head_i,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  input  logic [NUM_REQ*LAT_WIDTH-1:0]   req_lat_i,
  input  logic [PRIO_WIDTH-1:0]          start_i,
  output logic [NUM_REQ-1:0]             gnt_o,
  output logic [MAX_LAT*CNT_WIDTH-1:0]   inc_o
);

  localparam logic [CNT_WIDTH-1:0] CAP = CNT_WIDTH'(CDB_WIDTH);

  logic [CNT_WIDTH-1:0] run [MAX_LAT];
  logic [CNT_WIDTH-1:0] inc [MAX_LAT];
  logic [LAT_WIDTH-1:0] lat;
  logic [LAT_WIDTH-1:0] tgt;
  int                   lane;

  always_comb begin
    gnt_o = '0;
    lat   = '0;
    tgt   = '0;
    lane  = 0;
    for (int e = 0; e < MAX_LAT; e++) begin
      run[e] = ring_i[e*CNT_WIDTH +: CNT_WIDTH];
      inc[e] = '0;
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      lane = int'(start_i) + k;
      if (lane >= NUM_REQ) lane = lane - NUM_REQ;
      lat = req_lat_i[lane*LAT_WIDTH +: LAT_WIDTH];
      tgt = head_i + lat;
      // lat never exceeds MAX_LAT-1 by width, so only zero is illegal here.
      if (en_i && req_valid_i[lane] && (lat != '0) && (run[tgt] < CAP)) begin
        gnt_o[lane] = 1'b1;
        run[tgt]    = run[tgt] + CNT_WIDTH'(1);
        inc[tgt]    = inc[tgt] + CNT_WIDTH'(1);
      end
    end
    inc_o = '0;
    for (int e = 0; e < MAX_LAT; e++) begin
      inc_o[e*CNT_WIDTH +: CNT_WIDTH] = inc[e];
    end
  end

endmodule

// File: rtl/cdb_slot_scheduler.sv
// CDB slot reservation ring for fixed-latency issue; reports leftover slots
// for variable-latency results. `CDB_SCHED_RR_EN selects round-robin lane priority.
module cdb_slot_scheduler
  import cdb_slot_scheduler_pkg::*;
#(
  parameter int CDB_WIDTH = CDB_SZ,
  parameter int NUM_REQ   = NUM_ISSUE,
  parameter int MAX_LAT   = CDB_SCHED_DEPTH,
  parameter int LAT_WIDTH = $clog2(MAX_LAT),
  parameter int CNT_WIDTH = $clog2(CDB_WIDTH + 1)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*LAT_WIDTH-1:0] req_lat,
  output logic [NUM_REQ-1:0]           gnt,
  output logic [CNT_WIDTH-1:0]         resv_now,
  output logic [CNT_WIDTH-1:0]         free_now,
  output logic                         resv_full_next
);

  localparam int PRIO_WIDTH = prio_width(NUM_REQ);
  localparam logic [CNT_WIDTH-1:0] CAP = CNT_WIDTH'(CDB_WIDTH);

  logic [CNT_WIDTH-1:0]         ring_q [MAX_LAT];
  logic [CNT_WIDTH-1:0]         ring_d [MAX_LAT];
  logic [LAT_WIDTH-1:0]         head_q;
  logic [LAT_WIDTH-1:0]         head_d;
  logic [MAX_LAT*CNT_WIDTH-1:0] ring_flat;
  logic [MAX_LAT*CNT_WIDTH-1:0] inc_flat;
  logic [PRIO_WIDTH-1:0]        start;
  logic                         ovf;

  cdb_resv_grant #(
    .CDB_WIDTH (CDB_WIDTH),
    .NUM_REQ   (NUM_REQ),
    .MAX_LAT   (MAX_LAT),
    .LAT_WIDTH (LAT_WIDTH),
    .CNT_WIDTH (CNT_WIDTH),
    .PRIO_WIDTH(PRIO_WIDTH)
  ) u_grant (
    .en_i       (!reset && !flush),
    .ring_i     (ring_flat),
    .head_i     (head_q),
    .req_valid_i(req_valid),
    .req_lat_i  (req_lat),
    .start_i    (start),
    .gnt_o      (gnt),
    .inc_o      (inc_flat)
  );

  assign head_d = head_q + LAT_WIDTH'(1);

  // The slot leaving head is retired and reappears as the farthest, empty slot.
  always_comb begin
    ring_flat = '0;
    for (int e = 0; e < MAX_LAT; e++) begin
      ring_flat[e*CNT_WIDTH +: CNT_WIDTH] = ring_q[e];
      if (flush || (LAT_WIDTH'(e) == head_q)) begin
        ring_d[e] = '0;
      end else begin
        ring_d[e] = ring_q[e] + inc_flat[e*CNT_WIDTH +: CNT_WIDTH];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q <= '0;
      for (int e = 0; e < MAX_LAT; e++) ring_q[e] <= '0;
    end else begin
      head_q <= head_d;
      for (int e = 0; e < MAX_LAT; e++) ring_q[e] <= ring_d[e];
    end
  end

`ifdef CDB_SCHED_RR_EN
  logic [PRIO_WIDTH-1:0] prio_q;
  logic [PRIO_WIDTH-1:0] prio_d;
  int                    rr_lane;

  // Next start is one past the last lane granted in this cycle's scan order.
  always_comb begin
    prio_d  = prio_q;
    rr_lane = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rr_lane = int'(prio_q) + k;
      if (rr_lane >= NUM_REQ) rr_lane = rr_lane - NUM_REQ;
      if (gnt[rr_lane]) begin
        prio_d = (rr_lane + 1 == NUM_REQ) ? '0 : PRIO_WIDTH'(rr_lane + 1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prio_q <= '0;
    end else if (!flush && (|gnt)) begin
      prio_q <= prio_d;
    end
  end

  assign start = prio_q;
`else
  assign start = '0;
`endif

  assign resv_now       = reset ? '0 : ring_q[head_q];
  assign free_now       = CAP - resv_now;
  assign resv_full_next = !reset && (ring_q[head_d] == CAP);

  always_comb begin
    ovf = 1'b0;
    for (int e = 0; e < MAX_LAT; e++) begin
      if (ring_q[e] > CAP) ovf = 1'b1;
    end
  end

  a_no_overbook: assert property (@(posedge clock) disable iff (reset) !ovf);

endmodule

// File: tb/tb_cdb_slot_scheduler.sv
// Directed, table-driven bench for cdb_slot_scheduler (CDB_WIDTH=2, NUM_REQ=3, MAX_LAT=8).
module tb_cdb_slot_scheduler;

  logic       clock = 1'b0;
  logic       reset;
  logic       flush;
  logic [2:0] req_valid;
  logic [8:0] req_lat;
  logic [2:0] gnt;
  logic [1:0] resv_now;
  logic [1:0] free_now;
  logic       resv_full_next;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic       fl;
    logic [2:0] vld;
    logic [8:0] lat;
    logic [2:0] egnt;
    int         eresv;
    logic       efull;
  } vec_t;

  vec_t tbl[$];

  cdb_slot_scheduler #(
    .CDB_WIDTH(2),
    .NUM_REQ  (3),
    .MAX_LAT  (8)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .flush         (flush),
    .req_valid     (req_valid),
    .req_lat       (req_lat),
    .gnt           (gnt),
    .resv_now      (resv_now),
    .free_now      (free_now),
    .resv_full_next(resv_full_next)
  );

  always #5 clock = ~clock;

  task automatic add(input logic fl, input logic [2:0] vld, input int l2, input int l1,
                     input int l0, input logic [2:0] egnt, input int eresv, input logic efull);
    vec_t v;
    v.fl    = fl;
    v.vld   = vld;
    v.lat   = {3'(l2), 3'(l1), 3'(l0)};
    v.egnt  = egnt;
    v.eresv = eresv;
    v.efull = efull;
    tbl.push_back(v);
  endtask

  task automatic idle(input int eresv, input logic efull);
    add(1'b0, 3'b000, 0, 0, 0, 3'b000, eresv, efull);
  endtask

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [2:0] egnt, input int eresv,
                            input logic efull);
    check({tag, " gnt"}, int'(gnt), int'(egnt));
    check({tag, " resv_now"}, int'(resv_now), eresv);
    check({tag, " free_now"}, int'(free_now), 2 - eresv);
    check({tag, " resv_full_next"}, int'(resv_full_next), int'(efull));
  endtask

  task automatic drive(input logic fl, input logic [2:0] vld, input int l2, input int l1,
                       input int l0);
    flush     = fl;
    req_valid = vld;
    req_lat   = {3'(l2), 3'(l1), 3'(l0)};
  endtask

  initial begin
    logic [2:0] rr_exp [3];
`ifdef CDB_SCHED_RR_EN
    rr_exp[0] = 3'b011; rr_exp[1] = 3'b101; rr_exp[2] = 3'b110;
`else
    rr_exp[0] = 3'b011; rr_exp[1] = 3'b011; rr_exp[2] = 3'b011;
`endif

    // Cycle index c = edges since reset release; head = c mod 8.
    add(1'b0, 3'b111, 3, 3, 3, 3'b011, 0, 1'b0);   // c0: capacity 2 at c3
    idle(0, 1'b0);                                  // c1
    idle(0, 1'b1);                                  // c2: c3 full
    idle(2, 1'b0);                                  // c3
    idle(0, 1'b0);                                  // c4
    idle(0, 1'b0);                                  // c5
    add(1'b0, 3'b001, 0, 0, 4, 3'b001, 0, 1'b0);   // c6: head 6 -> entry 2
    idle(0, 1'b0);                                  // c7
    idle(0, 1'b0);                                  // c8
    idle(0, 1'b0);                                  // c9
    idle(1, 1'b0);                                  // c10
    add(1'b0, 3'b111, 1, 7, 0, 3'b110, 0, 1'b0);   // c11: lat 0 illegal
    idle(1, 1'b0);                                  // c12
    for (int i = 13; i <= 17; i++) idle(0, 1'b0);
    idle(1, 1'b0);                                  // c18
    add(1'b0, 3'b111, 1, 2, 2, 3'b111, 0, 1'b0);   // c19
    add(1'b0, 3'b001, 0, 0, 1, 3'b000, 1, 1'b1);   // c20: target already full
    idle(2, 1'b0);                                  // c21
    add(1'b0, 3'b011, 0, 5, 2, 3'b011, 0, 1'b0);   // c22
    add(1'b1, 3'b001, 0, 0, 1, 3'b000, 0, 1'b0);   // c23: flush
    for (int i = 24; i <= 31; i++) idle(0, 1'b0);
    add(1'b0, 3'b011, 0, 7, 7, 3'b011, 0, 1'b0);   // c32: entry 7
    for (int i = 33; i <= 37; i++) idle(0, 1'b0);
    idle(0, 1'b1);                                  // c38
    idle(2, 1'b0);                                  // c39
    idle(0, 1'b0);                                  // c40
    add(1'b0, 3'b111, 0, 0, 0, 3'b000, 0, 1'b0);   // c41: all illegal
    idle(0, 1'b0);                                  // c42

    reset = 1'b1;
    drive(1'b0, 3'b111, 1, 1, 1);
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_outs("reset", 3'b000, 0, 1'b0);
    @(posedge clock);
    #1 reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].fl, tbl[i].vld, int'(tbl[i].lat[8:6]), int'(tbl[i].lat[5:3]),
            int'(tbl[i].lat[2:0]));
      @(negedge clock);
      check_outs($sformatf("c%0d", i), tbl[i].egnt, tbl[i].eresv, tbl[i].efull);
      @(posedge clock);
      #1;
    end

    // Reset mid-operation, together with flush, discards pending reservations.
    drive(1'b0, 3'b011, 0, 3, 3);
    @(negedge clock);
    check_outs("mr_req", 3'b011, 0, 1'b0);
    @(posedge clock);
    #1 reset = 1'b1;
    drive(1'b1, 3'b111, 1, 1, 1);
    @(negedge clock);
    check_outs("mr_rst", 3'b000, 0, 1'b0);
    @(posedge clock);
    #1 reset = 1'b0;
    drive(1'b0, 3'b000, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check_outs($sformatf("mr_post%0d", k), 3'b000, 0, 1'b0);
      @(posedge clock);
      #1;
    end

    // Three lanes contending for one slot per cycle, three cycles running.
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 3'b111, 2, 2, 2);
      @(negedge clock);
      check_outs($sformatf("rr%0d", k), rr_exp[k], (k == 2) ? 2 : 0, k != 0);
      @(posedge clock);
      #1;
    end
    drive(1'b0, 3'b000, 0, 0, 0);
    @(negedge clock);
    check_outs("rr_tail", 3'b000, 2, 1'b1);
    @(posedge clock);
    #1;
    @(negedge clock);
    check_outs("rr_tail2", 3'b000, 2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
